// File: rtl/obj_sprite_engine.sv
// obj_sprite_engine: run-time object table, collect/frame-tick progression, sprite-sheet addressing.
// Optional blink of the visible object with `define OBJ_BLINK_EN.
module obj_sprite_engine #(
  parameter int NUM_OBJ      = 3,
  parameter int SPR_W        = 20,
  parameter int SPR_H        = 20,
  parameter int FB_W         = 320,
  parameter int ROM_SIZE     = 76800,
  parameter int ACTIVE_STATE = 2,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  state,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        frame_tick,
  input  logic        collect,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_idx,
  input  logic        cfg_en,
  input  logic [8:0]  cfg_x,
  input  logic [8:0]  cfg_y,
  input  logic [8:0]  cfg_sx,
  input  logic [8:0]  cfg_sy,
  output logic [16:0] pixel_addr,
  output logic        isObject,
  output logic [2:0]  cur_obj,
  output logic        all_found
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_DONE
  } fsm_t;

  fsm_t       fsm;
  logic [3:0] cur;
  logic       pending;
  logic       active;

  logic       t_en [NUM_OBJ];
  logic [8:0] t_x  [NUM_OBJ];
  logic [8:0] t_y  [NUM_OBJ];
  logic [8:0] t_sx [NUM_OBJ];
  logic [8:0] t_sy [NUM_OBJ];

  logic       sel_en;
  logic [8:0] sel_x;
  logic [8:0] sel_y;
  logic [8:0] sel_sx;
  logic [8:0] sel_sy;

  logic [9:0]  px;
  logic [9:0]  py;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic        in_x;
  logic        in_y;
  logic        hit;
  logic        vis;
  logic [17:0] addr_raw;
  logic [17:0] addr_mod;

  assign active  = (state == 4'(ACTIVE_STATE));
  assign cur_obj = cur[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        t_en[i] <= 1'b0;
        t_x[i]  <= '0;
        t_y[i]  <= '0;
        t_sx[i] <= '0;
        t_sy[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (cfg_idx == 3'(i)) begin
          t_en[i] <= cfg_en;
          t_x[i]  <= cfg_x;
          t_y[i]  <= cfg_y;
          t_sx[i] <= cfg_sx;
          t_sy[i] <= cfg_sy;
        end
      end
    end
  end

  // cur == NUM_OBJ selects nothing, so the entry reads as disabled
  always_comb begin
    sel_en = 1'b0;
    sel_x  = '0;
    sel_y  = '0;
    sel_sx = '0;
    sel_sy = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (cur == 4'(i)) begin
        sel_en = t_en[i];
        sel_x  = t_x[i];
        sel_y  = t_y[i];
        sel_sx = t_sx[i];
        sel_sy = t_sy[i];
      end
    end
  end

  assign px   = {1'b0, h_cnt[9:1]};
  assign py   = {1'b0, v_cnt[9:1]};
  assign dx   = px - {1'b0, sel_x};
  assign dy   = py - {1'b0, sel_y};
  assign in_x = (px >= {1'b0, sel_x}) &&
                (px < ({1'b0, sel_x} + 10'(SPR_W)));
  assign in_y = (py >= {1'b0, sel_y}) &&
                (py < ({1'b0, sel_y} + 10'(SPR_H)));
  assign hit  = (fsm == S_SHOW) && sel_en && in_x && in_y;

  assign addr_raw = 18'(sel_sx) + 18'(dx) +
                    (18'(sel_sy) + 18'(dy)) * 18'(FB_W);
  assign addr_mod = addr_raw % 18'(ROM_SIZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      cur       <= '0;
      pending   <= 1'b0;
      all_found <= 1'b0;
    end else begin
      all_found <= 1'b0;
      if (!active) begin
        fsm     <= S_IDLE;
        cur     <= '0;
        pending <= 1'b0;
      end else begin
        unique case (fsm)
          S_IDLE: begin
            fsm     <= S_SHOW;
            cur     <= '0;
            pending <= 1'b0;
          end
          S_SHOW: begin
            if (frame_tick && (pending || collect)) begin
              cur     <= cur + 4'd1;
              pending <= 1'b0;
              if (cur + 4'd1 == 4'(NUM_OBJ)) begin
                fsm       <= S_DONE;
                all_found <= 1'b1;
              end
            end else if (collect) begin
              pending <= 1'b1;
            end
          end
          S_DONE: cur <= 4'(NUM_OBJ);
          default: fsm <= S_IDLE;
        endcase
      end
    end
  end

`ifdef OBJ_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0] blink_cnt;
  logic          hide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      hide      <= 1'b0;
    end else if (active && fsm == S_IDLE) begin
      blink_cnt <= '0;
      hide      <= 1'b0;
    end else if (active && fsm == S_SHOW && frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        hide      <= ~hide;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign vis = ~hide;

  logic unused_ok;
  assign unused_ok = ^{h_cnt[0], v_cnt[0], addr_mod[17], cur[3]};
`else
  assign vis = 1'b1;

  logic unused_ok;
  assign unused_ok = ^{h_cnt[0], v_cnt[0], addr_mod[17], cur[3],
                       32'(BLINK_FRAMES)};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_addr <= '0;
      isObject   <= 1'b0;
    end else begin
      isObject <= hit & vis;
      if (hit) pixel_addr <= addr_mod[16:0];
    end
  end

endmodule

// File: tb/tb_obj_sprite_engine.sv
// tb_obj_sprite_engine: directed literal checks plus randomized run
// against a rule-level model of the object engine.
module tb_obj_sprite_engine;

  localparam int NO  = 3;
  localparam int SW  = 20;
  localparam int SH  = 20;
  localparam int FBW = 320;
  localparam int RS  = 76800;
  localparam int ACT = 2;
  localparam int BF  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  state;
  logic [9:0]  h_cnt, v_cnt;
  logic        frame_tick, collect;
  logic        cfg_we, cfg_en;
  logic [2:0]  cfg_idx;
  logic [8:0]  cfg_x, cfg_y, cfg_sx, cfg_sy;
  logic [16:0] pixel_addr;
  logic        isObject;
  logic [2:0]  cur_obj;
  logic        all_found;

  obj_sprite_engine #(
    .NUM_OBJ(NO), .SPR_W(SW), .SPR_H(SH), .FB_W(FBW),
    .ROM_SIZE(RS), .ACTIVE_STATE(ACT), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_tick(frame_tick), .collect(collect),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_sx(cfg_sx), .cfg_sy(cfg_sy),
    .pixel_addr(pixel_addr), .isObject(isObject),
    .cur_obj(cur_obj), .all_found(all_found)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // model: phase 0=idle 1=show 2=done
  int m_en[NO], m_x[NO], m_y[NO], m_sx[NO], m_sy[NO];
  int m_phase, m_cur, m_pend, m_ticks;
  int exp_addr, exp_obj, exp_af;

  function automatic void model_reset();
    for (int i = 0; i < NO; i++) begin
      m_en[i] = 0; m_x[i] = 0; m_y[i] = 0;
      m_sx[i] = 0; m_sy[i] = 0;
    end
    m_phase = 0; m_cur = 0; m_pend = 0; m_ticks = 0;
    exp_addr = 0; exp_obj = 0; exp_af = 0;
  endfunction

  function automatic void model_step();
    int x, y, c;
    bit hit, hidden;
    x = int'(h_cnt) / 2;
    y = int'(v_cnt) / 2;
    c = m_cur;
    hidden = 1'b0;
`ifdef OBJ_BLINK_EN
    hidden = ((m_ticks / BF) % 2) == 1;
`endif
    hit = (m_phase == 1) && (c < NO);
    if (hit)
      hit = (m_en[c] != 0) &&
            x >= m_x[c] && x < m_x[c] + SW &&
            y >= m_y[c] && y < m_y[c] + SH;
    exp_obj = (hit && !hidden) ? 1 : 0;
    if (hit)
      exp_addr = ((m_sx[c] + x - m_x[c]) +
                  (m_sy[c] + y - m_y[c]) * FBW) % RS;
    exp_af = 0;
    if (int'(state) != ACT) begin
      m_phase = 0; m_cur = 0; m_pend = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_cur = 0; m_pend = 0; m_ticks = 0;
    end else if (m_phase == 1) begin
      if (frame_tick) m_ticks++;
      if (frame_tick && (m_pend != 0 || collect)) begin
        m_cur++;
        m_pend = 0;
        if (m_cur == NO) begin
          m_phase = 2;
          exp_af = 1;
        end
      end else if (collect) begin
        m_pend = 1;
      end
    end
    if (cfg_we && int'(cfg_idx) < NO) begin
      m_en[cfg_idx] = int'(cfg_en);
      m_x[cfg_idx]  = int'(cfg_x);
      m_y[cfg_idx]  = int'(cfg_y);
      m_sx[cfg_idx] = int'(cfg_sx);
      m_sy[cfg_idx] = int'(cfg_sy);
    end
  endfunction

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      model_step();
      #1;
      chk("m_addr", 32'(pixel_addr), exp_addr);
      chk("m_obj", 32'(isObject), exp_obj);
      chk("m_cur", 32'(cur_obj), m_cur);
      chk("m_af", 32'(all_found), exp_af);
    end
  end

  task automatic cfg(input int idx, input int en, input int x,
                     input int y, input int sx, input int sy);
    cfg_we = 1'b1;
    cfg_idx = 3'(idx); cfg_en = en[0];
    cfg_x = 9'(x); cfg_y = 9'(y);
    cfg_sx = 9'(sx); cfg_sy = 9'(sy);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input bit c, input bit t);
    collect = c;
    frame_tick = t;
    @(negedge clk);
    collect = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    int tx, ty;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 299) == 0)
        state = 4'($urandom_range(0, 3));
      else if (state != 4'(ACT) && $urandom_range(0, 19) == 0)
        state = 4'(ACT);
      collect    = ($urandom_range(0, 39) == 0);
      frame_tick = ($urandom_range(0, 24) == 0);
      cfg_we     = ($urandom_range(0, 49) == 0);
      cfg_idx    = 3'($urandom_range(0, 7));
      cfg_en     = ($urandom_range(0, 4) != 0);
      cfg_x      = 9'($urandom_range(0, 319));
      cfg_y      = 9'($urandom_range(0, 239));
      cfg_sx     = 9'($urandom_range(0, 511));
      cfg_sy     = 9'($urandom_range(0, 511));
      if (m_cur < NO && $urandom_range(0, 9) < 7) begin
        tx = m_x[m_cur] + int'($urandom_range(0, SW + 3)) - 2;
        ty = m_y[m_cur] + int'($urandom_range(0, SH + 3)) - 2;
        if (tx < 0) tx = 0;
        if (ty < 0) ty = 0;
        h_cnt = 10'((tx % 512) * 2 + int'($urandom_range(0, 1)));
        v_cnt = 10'((ty % 512) * 2 + int'($urandom_range(0, 1)));
      end else begin
        h_cnt = 10'($urandom_range(0, 1023));
        v_cnt = 10'($urandom_range(0, 1023));
      end
      @(negedge clk);
    end
    collect = 1'b0; frame_tick = 1'b0; cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    state = 4'd0; h_cnt = '0; v_cnt = '0;
    frame_tick = 1'b0; collect = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
    cfg_x = '0; cfg_y = '0; cfg_sx = '0; cfg_sy = '0;
    model_reset();
    #2;
    chk("rst_addr", 32'(pixel_addr), 0);
    chk("rst_obj", 32'(isObject), 0);
    chk("rst_cur", 32'(cur_obj), 0);
    chk("rst_af", 32'(all_found), 0);
    @(negedge clk);
    rst_n = 1'b1;
    state = 4'(ACT);
    cfg(0, 1, 65, 35, 0, 120);
    h_cnt = 10'd140; v_cnt = 10'd80;
    @(negedge clk);
    chk("hit_obj", 32'(isObject), 1);
    chk("hit_addr", 32'(pixel_addr), 40005);
    h_cnt = 10'd170;
    @(negedge clk);
    chk("right_edge_obj", 32'(isObject), 0);
    chk("hold_addr", 32'(pixel_addr), 40005);
    h_cnt = 10'd168; v_cnt = 10'd108;
    @(negedge clk);
    chk("corner_obj", 32'(isObject), 1);
    chk("corner_addr", 32'(pixel_addr), 44499);
    v_cnt = 10'd110;
    @(negedge clk);
    chk("bottom_edge_obj", 32'(isObject), 0);

    pulse(1'b1, 1'b0);
    @(negedge clk);
    chk("pend_cur", 32'(cur_obj), 0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("tick_cur", 32'(cur_obj), 1);
    pulse(1'b0, 1'b1);
    chk("dup_collect_cur", 32'(cur_obj), 1);
    cfg(1, 1, 200, 100, 40, 40);
    cfg(2, 1, 10, 10, 500, 300);
    pulse(1'b1, 1'b1);
    chk("same_cycle_cur", 32'(cur_obj), 2);
    h_cnt = 10'd24; v_cnt = 10'd22;
    @(negedge clk);
    chk("wrap_obj", 32'(isObject), 1);
    chk("wrap_addr", 32'(pixel_addr), 20022);
    pulse(1'b1, 1'b1);
    chk("done_cur", 32'(cur_obj), 3);
    chk("done_af", 32'(all_found), 1);
    @(negedge clk);
    chk("af_pulse_end", 32'(all_found), 0);
    chk("done_obj", 32'(isObject), 0);

    state = 4'd0;
    @(negedge clk);
    chk("idle_cur", 32'(cur_obj), 0);
    state = 4'(ACT);
    @(negedge clk);
    pulse(1'b1, 1'b0);
    state = 4'd0;
    @(negedge clk);
    state = 4'(ACT);
    @(negedge clk);
    pulse(1'b0, 1'b1);
    chk("pend_cleared_cur", 32'(cur_obj), 0);

    rand_cycles(4000);

    #3;
    rst_n = 1'b0;
    #1;
    chk("async_addr", 32'(pixel_addr), 0);
    chk("async_obj", 32'(isObject), 0);
    chk("async_cur", 32'(cur_obj), 0);
    chk("async_af", 32'(all_found), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rand_cycles(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
